// File: rtl/prelude_pkg.sv
// prelude_pkg: shared encodings for the Prelude pipelined core.
package prelude_pkg;

  localparam int unsigned INSTR_W = 8;

  // Major opcode in instruction bits [7:6]
  localparam logic [1:0] OPC_IMM    = 2'b00;
  localparam logic [1:0] OPC_CALC   = 2'b01;
  localparam logic [1:0] OPC_COPY   = 2'b10;
  localparam logic [1:0] OPC_BRANCH = 2'b11;

  // Register index that maps onto the RIO ports
  localparam logic [2:0] RIO_IDX = 3'd7;

  // Overture-style instruction word
  typedef struct packed {
    logic [1:0] opc;
    logic [5:0] arg;
  } instr_t;

  // Calculate operations; codes 8..63 produce zero
  typedef enum logic [5:0] {
    ALU_OR   = 6'd0,
    ALU_NAND = 6'd1,
    ALU_NOR  = 6'd2,
    ALU_AND  = 6'd3,
    ALU_ADD  = 6'd4,
    ALU_SUB  = 6'd5,
    ALU_XOR  = 6'd6,
    ALU_SHL  = 6'd7
  } alu_op_e;

  // Branch conditions, tested against r3
  typedef enum logic [2:0] {
    COND_NEVER  = 3'd0,
    COND_EQZ    = 3'd1,
    COND_LTZ    = 3'd2,
    COND_LEZ    = 3'd3,
    COND_ALWAYS = 3'd4,
    COND_NEZ    = 3'd5,
    COND_GEZ    = 3'd6,
    COND_GTZ    = 3'd7
  } cond_e;

endpackage

// File: rtl/prelude_alu.sv
// prelude_alu: combinational calculate unit (r1 op r2).
// Optional: define PRELUDE_SHL_EN to give op 7 a left shifter; otherwise op 7 yields 0.
module prelude_alu
  import prelude_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

`ifdef PRELUDE_SHL_EN
  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] shl;

  // Shift amounts at or beyond the data width flush everything out
  always_comb begin
    shl = '0;
    if (b < DATA_W'(DATA_W)) shl = a << b[SH_W-1:0];
  end
`endif

  // Operation select, wraps modulo 2^DATA_W
  always_comb begin
    y = '0;
    case (op)
      ALU_OR:   y = a | b;
      ALU_NAND: y = ~(a & b);
      ALU_NOR:  y = ~(a | b);
      ALU_AND:  y = a & b;
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_XOR:  y = a ^ b;
`ifdef PRELUDE_SHL_EN
      ALU_SHL:  y = shl;
`else
      ALU_SHL:  y = '0;
`endif
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/prelude_core.sv
// prelude_core: two-stage (fetch/execute) Prelude CPU with valid/ready RIO ports.
// Optional: PRELUDE_SHL_EN enables the shifter inside prelude_alu.
module prelude_core
  import prelude_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic [DATA_W-1:0]  rio_in,
  input  logic               rio_in_valid,
  output logic               rio_in_ready,
  output logic [DATA_W-1:0]  rio_out,
  output logic               rio_out_valid,
  input  logic               rio_out_ready
);

  logic [ADDR_W-1:0] pc;
  logic              e_valid;
  logic [DATA_W-1:0] regs [8];

  instr_t            ins;
  logic [2:0]        src;
  logic [2:0]        dst;
  logic              is_copy;
  logic              is_branch;
  logic              rd_rio;
  logic              wr_rio;
  logic              stall;
  logic              exec;
  logic              cond_ok;
  logic              taken;
  logic [DATA_W-1:0] src_val;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] r3;

  // Decode the E-stage word (memory holds it while fetch is stalled) and derive stall
  always_comb begin
    ins       = instr_t'(imem_rdata);
    src       = ins.arg[5:3];
    dst       = ins.arg[2:0];
    is_copy   = (ins.opc == OPC_COPY);
    is_branch = (ins.opc == OPC_BRANCH);
    rd_rio    = e_valid && is_copy && (src == RIO_IDX);
    wr_rio    = e_valid && is_copy && (dst == RIO_IDX);
    stall     = (rd_rio && !rio_in_valid) ||
                (wr_rio && rio_out_valid && !rio_out_ready);
    exec      = e_valid && !stall;
    src_val   = (src == RIO_IDX) ? rio_in : regs[src];
  end

  // Branch condition on r3 (sign bit for the signed tests)
  always_comb begin
    r3      = regs[3];
    cond_ok = 1'b0;
    case (cond_e'(ins.arg[2:0]))
      COND_NEVER:  cond_ok = 1'b0;
      COND_EQZ:    cond_ok = (r3 == '0);
      COND_LTZ:    cond_ok = r3[DATA_W-1];
      COND_LEZ:    cond_ok = r3[DATA_W-1] || (r3 == '0);
      COND_ALWAYS: cond_ok = 1'b1;
      COND_NEZ:    cond_ok = (r3 != '0);
      COND_GEZ:    cond_ok = !r3[DATA_W-1];
      COND_GTZ:    cond_ok = !r3[DATA_W-1] && (r3 != '0);
      default:     cond_ok = 1'b0;
    endcase
    taken = exec && is_branch && cond_ok;
  end

  prelude_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op (alu_op_e'(ins.arg)),
    .a  (regs[1]),
    .b  (regs[2]),
    .y  (alu_y)
  );

  // Fetch control: stall freezes pc and E; a taken branch flushes the word in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc      <= '0;
      e_valid <= 1'b0;
    end else if (!stall) begin
      if (taken) begin
        pc      <= ADDR_W'(regs[0]);
        e_valid <= 1'b0;
      end else begin
        pc      <= pc + ADDR_W'(1);
        e_valid <= 1'b1;
      end
    end
  end

  // Register file write-back at the end of E; slot 7 is never written
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (exec) begin
      case (ins.opc)
        OPC_IMM:  regs[0] <= DATA_W'(ins.arg);
        OPC_CALC: regs[3] <= alu_y;
        OPC_COPY: if (dst != RIO_IDX) regs[dst] <= src_val;
        default:  ;
      endcase
    end
  end

  // RIO output holding register: a new write wins over a completing transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rio_out       <= '0;
      rio_out_valid <= 1'b0;
    end else if (exec && wr_rio) begin
      rio_out       <= src_val;
      rio_out_valid <= 1'b1;
    end else if (rio_out_valid && rio_out_ready) begin
      rio_out_valid <= 1'b0;
    end
  end

  // Memory and input-port strobes follow the stall decision directly
  always_comb begin
    imem_en      = reset_n && !stall;
    imem_addr    = pc;
    rio_in_ready = exec && rd_rio;
  end

endmodule

// File: tb/tb_prelude_core.sv
// tb_prelude_core: directed programs against an instruction-level reference model.
module tb_prelude_core;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  logic          clk;
  logic          reset_n;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [7:0]    imem_rdata;
  logic [DW-1:0] rio_in;
  logic          rio_in_valid;
  logic          rio_in_ready;
  logic [DW-1:0] rio_out;
  logic          rio_out_valid;
  logic          rio_out_ready;

  prelude_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .rio_in        (rio_in),
    .rio_in_valid  (rio_in_valid),
    .rio_in_ready  (rio_in_ready),
    .rio_out       (rio_out),
    .rio_out_valid (rio_out_valid),
    .rio_out_ready (rio_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory: synchronous read, output held while not enabled
  logic [7:0] mem [256];
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  int total;
  int bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Architectural model: next fetch address, address of the word in E, registers, RIO out
  logic [AW-1:0] m_pc;
  logic          m_ev;
  logic [AW-1:0] m_eaddr;
  logic [DW-1:0] m_r [8];
  logic [DW-1:0] m_out;
  logic          m_outv;
  int            cyc;

  // Observations per run
  logic [AW-1:0] log_addr [64];
  logic          log_en   [64];
  logic [DW-1:0] log_out  [64];
  logic [DW-1:0] xfers [$];
  int inr_cnt, inr_cyc, enlo, vcnt, first_v;

  function automatic logic [DW-1:0] m_calc(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      0: return a | b;
      1: return ~(a & b);
      2: return ~(a | b);
      3: return a & b;
      4: return DW'(int'(a) + int'(b));
      5: return DW'(int'(a) - int'(b));
      6: return a ^ b;
`ifdef PRELUDE_SHL_EN
      7: return (int'(b) >= DW) ? '0 : DW'(int'(a) * (1 << int'(b)));
`endif
      default: return '0;
    endcase
  endfunction

  function automatic logic m_cond(input int c, input logic [DW-1:0] v);
    logic signed [DW-1:0] sv;
    sv = $signed(v);
    case (c)
      1: return v == '0;
      2: return sv < 0;
      3: return sv <= 0;
      4: return 1'b1;
      5: return v != '0;
      6: return sv >= 0;
      7: return sv > 0;
      default: return 1'b0;
    endcase
  endfunction

  // Per-cycle comparison against the model, then advance the model by one clock
  always @(negedge clk) begin : cmp
    logic [7:0]    ins;
    logic [2:0]    s;
    logic [2:0]    d;
    logic          rd7, wr7, stl, wrote, tk;
    logic [DW-1:0] v;
    if (!reset_n) begin
      chk("rst_en", 32'(imem_en), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_in_ready", 32'(rio_in_ready), 32'd0);
      chk("rst_out_valid", 32'(rio_out_valid), 32'd0);
      chk("rst_out", 32'(rio_out), 32'd0);
      m_pc = '0; m_ev = 1'b0; m_eaddr = '0; m_out = '0; m_outv = 1'b0;
      for (int i = 0; i < 8; i++) m_r[i] = '0;
      cyc = 0;
    end else begin
      ins = mem[m_eaddr];
      s   = ins[5:3];
      d   = ins[2:0];
      rd7 = m_ev && ins[7:6] == 2'b10 && s == 3'd7;
      wr7 = m_ev && ins[7:6] == 2'b10 && d == 3'd7;
      stl = (rd7 && !rio_in_valid) || (wr7 && m_outv && !rio_out_ready);
      chk("en", 32'(imem_en), 32'(!stl));
      chk("addr", 32'(imem_addr), 32'(m_pc));
      chk("in_ready", 32'(rio_in_ready), 32'(rd7 && !stl));
      chk("out_valid", 32'(rio_out_valid), 32'(m_outv));
      chk("out", 32'(rio_out), 32'(m_out));
      if (cyc < 64) begin
        log_addr[cyc] = imem_addr; log_en[cyc] = imem_en; log_out[cyc] = rio_out;
      end
      if (rio_out_valid && rio_out_ready) xfers.push_back(rio_out);
      if (rio_in_ready) begin inr_cnt++; inr_cyc = cyc; end
      if (!imem_en) enlo++;
      if (rio_out_valid) begin vcnt++; if (first_v < 0) first_v = cyc; end
      wrote = 1'b0;
      tk    = 1'b0;
      if (m_ev && !stl) begin
        case (ins[7:6])
          2'b00: m_r[0] = DW'(ins[5:0]);
          2'b01: m_r[3] = m_calc(int'(ins[5:0]), m_r[1], m_r[2]);
          2'b10: begin
            v = (s == 3'd7) ? rio_in : m_r[s];
            if (d == 3'd7) begin m_out = v; wrote = 1'b1; end
            else m_r[d] = v;
          end
          default: tk = m_cond(int'(ins[2:0]), m_r[3]);
        endcase
      end
      if (wrote) m_outv = 1'b1;
      else if (m_outv && rio_out_ready) m_outv = 1'b0;
      if (!stl) begin
        if (tk) begin
          m_pc = AW'(m_r[0]);
          m_ev = 1'b0;
        end else begin
          m_eaddr = m_pc;
          m_pc    = m_pc + AW'(1);
          m_ev    = 1'b1;
        end
      end
      cyc++;
    end
  end

  logic [7:0]    prog [$];
  logic [DW-1:0] exp_x [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    xfers.delete();
    inr_cnt = 0; inr_cyc = -1; enlo = 0; vcnt = 0; first_v = -1;
  endtask

  // Reset, load prog, set port levels, release at the start of cycle 0
  task automatic start(input logic out_ready, input logic in_valid, input logic [DW-1:0] in_data);
    step();
    reset_n = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    foreach (prog[i]) mem[i] = prog[i];
    rio_in = in_data; rio_in_valid = in_valid; rio_out_ready = out_ready;
    clear_stats();
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic check_xfers(input string nm);
    chk({nm, "_count"}, 32'(xfers.size()), 32'(exp_x.size()));
    foreach (exp_x[i])
      chk({nm, "_data"}, (i < xfers.size()) ? 32'(xfers[i]) : 32'hDEAD, 32'(exp_x[i]));
  endtask

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; rio_in = '0; rio_in_valid = 1'b0; rio_out_ready = 1'b0; imem_rdata = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset values
    #12;
    chk("reset_imem_en", 32'(imem_en), 32'd0);
    chk("reset_out_valid", 32'(rio_out_valid), 32'd0);
    chk("reset_pc", 32'(imem_addr), 32'd0);

    // ADD: r3 = 5 + 3, emitted once at cycle 7
    prog = {8'h05, 8'h81, 8'h03, 8'h82, 8'h44, 8'h9F};
    start(1'b1, 1'b0, '0);
    repeat (12) step();
    chk("add_first_fetch_en", 32'(log_en[0]), 32'd1);
    chk("add_first_fetch_addr", 32'(log_addr[0]), 32'd0);
    chk("add_valid_cycle", 32'(first_v), 32'd7);
    chk("add_valid_len", 32'(vcnt), 32'd1);
    exp_x = {8'h08};
    check_xfers("add");

    // Taken branch: fetch order 0,1,2,0,1
    prog = {8'h00, 8'hC4};
    start(1'b1, 1'b0, '0);
    repeat (10) step();
    chk("bra_addr0", 32'(log_addr[0]), 32'd0);
    chk("bra_addr1", 32'(log_addr[1]), 32'd1);
    chk("bra_addr2", 32'(log_addr[2]), 32'd2);
    chk("bra_addr3", 32'(log_addr[3]), 32'd0);
    chk("bra_addr4", 32'(log_addr[4]), 32'd1);

    // Input stall: r1 <- r7 waits three cycles for data 0x2A, then r7 <- r1
    prog = {8'hB9, 8'h8F};
    start(1'b1, 1'b0, '0);
    repeat (4) step();
    rio_in = 8'h2A; rio_in_valid = 1'b1;
    step();
    rio_in = 8'h00; rio_in_valid = 1'b0;
    repeat (6) step();
    chk("install_en_low", 32'(enlo), 32'd3);
    chk("install_ready_pulses", 32'(inr_cnt), 32'd1);
    chk("install_ready_cycle", 32'(inr_cyc), 32'd4);
    exp_x = {8'h2A};
    check_xfers("install");

    // Output backpressure: writes of 1 then 2, sink blocked cycles 0..5
    prog = {8'h01, 8'h87, 8'h02, 8'h87};
    start(1'b0, 1'b0, '0);
    repeat (6) step();
    rio_out_ready = 1'b1;
    repeat (6) step();
    chk("bp_en_low", 32'(enlo), 32'd2);
    chk("bp_out_c5", 32'(log_out[5]), 32'd1);
    chk("bp_out_c7", 32'(log_out[7]), 32'd2);
    exp_x = {8'h01, 8'h02};
    check_xfers("bp");

    // Op 7 with r1=1, r2=7, then BLT to 12 on r3
    prog = {8'h01, 8'h81, 8'h07, 8'h82, 8'h47, 8'h9F, 8'h0C, 8'hC2,
            8'h05, 8'h87, 8'h00, 8'h00, 8'h06, 8'h87};
    start(1'b1, 1'b0, '0);
    repeat (24) step();
`ifdef PRELUDE_SHL_EN
    exp_x = {8'h80, 8'h06};
`else
    exp_x = {8'h00, 8'h05, 8'h06};
`endif
    check_xfers("shl7");

    // Op 7 with r2 equal to the data width gives 0, so BLT falls through
    prog[2] = 8'h08;
    start(1'b1, 1'b0, '0);
    repeat (24) step();
    exp_x = {8'h00, 8'h05, 8'h06};
    check_xfers("shl8");

    // ALU sweep with r1=0x35, r2=0x1A, then 1-2 wrap
    prog = {8'h35, 8'h81, 8'h1A, 8'h82,
            8'h40, 8'h9F, 8'h41, 8'h9F, 8'h42, 8'h9F, 8'h43, 8'h9F, 8'h44, 8'h9F,
            8'h45, 8'h9F, 8'h46, 8'h9F, 8'h47, 8'h9F, 8'h48, 8'h9F,
            8'h01, 8'h81, 8'h02, 8'h82, 8'h45, 8'h9F};
    start(1'b1, 1'b0, '0);
    repeat (34) step();
    exp_x = {8'h3F, 8'hEF, 8'hC0, 8'h10, 8'h4F, 8'h1B, 8'h2F, 8'h00, 8'h00, 8'hFF};
    check_xfers("alu");

    // Reset while stalled on a pending output
    prog = {8'h01, 8'h87, 8'h02, 8'h87};
    start(1'b0, 1'b0, '0);
    repeat (6) step();
    chk("mid_pre_valid", 32'(rio_out_valid), 32'd1);
    chk("mid_pre_en", 32'(imem_en), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rio_out_valid), 32'd0);
    chk("mid_rst_en", 32'(imem_en), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    step();
    step();
    clear_stats();
    reset_n = 1'b1;
    repeat (4) step();
    chk("mid_restart_en", 32'(log_en[0]), 32'd1);
    chk("mid_restart_addr0", 32'(log_addr[0]), 32'd0);
    chk("mid_restart_addr1", 32'(log_addr[1]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
